// File: rtl/sram_cmd_queue.sv
// Command FIFO feeding a single-outstanding SRAM controller handshake (issue, ready low, ready high).
// Define SRAM_CMDQ_TIMEOUT_EN to add a watchdog on the controller handshake with a sticky err flag.
module sram_cmd_queue #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [17:0] cmd_addr,
    input  logic [15:0] cmd_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_data,
    output logic        err,
    output logic        write,
    output logic        read,
    output logic [17:0] address,
    output logic [15:0] data_write,
    input  logic [15:0] data_read,
    input  logic        ready
);
    localparam int AW = $clog2(DEPTH);
    localparam int EW = 35;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_LO = 2'd1,
        WAIT_HI = 2'd2
    } state_t;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1) begin : g_param_check
        $error("sram_cmd_queue: DEPTH must be a power of two >= 2 and TIMEOUT >= 1");
    end

    logic [EW-1:0] mem [DEPTH];
    logic [AW:0]   wr_ptr_reg;
    logic [AW:0]   rd_ptr_reg;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic [EW-1:0] head;

    state_t        state_reg;
    state_t        state_next;
    logic          write_reg;
    logic          write_next;
    logic          read_reg;
    logic          read_next;
    logic          rsp_valid_reg;
    logic          rsp_valid_next;
    logic [15:0]   rsp_data_reg;
    logic [15:0]   rsp_data_next;
    logic [17:0]   address_reg;
    logic [15:0]   data_write_reg;
    logic          cur_write_reg;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty     = (wr_ptr_reg == rd_ptr_reg);
    assign full      = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                       (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign cmd_ready = !full;
    assign push      = cmd_valid && cmd_ready;
    assign head      = mem[rd_ptr_reg[AW-1:0]];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg[AW-1:0]] <= {cmd_write, cmd_addr, cmd_wdata};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
        end
    end

`ifdef SRAM_CMDQ_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] timer_reg;
    logic          err_reg;
    logic          err_next;

    // Restarts on every state change, so each wait phase gets its own TIMEOUT budget.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            timer_reg <= '0;
            err_reg   <= 1'b0;
        end else begin
            err_reg <= err_next;
            if (state_next != state_reg) begin
                timer_reg <= '0;
            end else if (state_reg != IDLE) begin
                timer_reg <= timer_reg + 1'b1;
            end
        end
    end

    assign err = err_reg;
`else
    assign err = 1'b0;
`endif

    always_comb begin
        state_next     = state_reg;
        pop            = 1'b0;
        write_next     = 1'b0;
        read_next      = 1'b0;
        rsp_valid_next = 1'b0;
        rsp_data_next  = rsp_data_reg;
`ifdef SRAM_CMDQ_TIMEOUT_EN
        err_next       = err_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (!empty && ready) begin
                    state_next = WAIT_LO;
                    pop        = 1'b1;
                    write_next = head[EW-1];
                    read_next  = !head[EW-1];
                end
            end
            WAIT_LO: begin
                if (!ready) begin
                    state_next = WAIT_HI;
                end
            end
            WAIT_HI: begin
                if (ready) begin
                    state_next = IDLE;
                    if (!cur_write_reg) begin
                        rsp_valid_next = 1'b1;
                        rsp_data_next  = data_read;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
`ifdef SRAM_CMDQ_TIMEOUT_EN
        // A normal handshake step wins over the watchdog in the same cycle.
        if (state_reg != IDLE && state_next == state_reg &&
            timer_reg == CW'(TIMEOUT - 1)) begin
            state_next = IDLE;
            err_next   = 1'b1;
            if (!cur_write_reg) begin
                rsp_valid_next = 1'b1;
                rsp_data_next  = 16'hDEAD;
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg      <= IDLE;
            write_reg      <= 1'b0;
            read_reg       <= 1'b0;
            rsp_valid_reg  <= 1'b0;
            rsp_data_reg   <= '0;
            address_reg    <= '0;
            data_write_reg <= '0;
            cur_write_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            write_reg     <= write_next;
            read_reg      <= read_next;
            rsp_valid_reg <= rsp_valid_next;
            rsp_data_reg  <= rsp_data_next;
            // Captured once at issue and held for the whole handshake.
            if (pop) begin
                address_reg    <= head[33:16];
                data_write_reg <= head[15:0];
                cur_write_reg  <= head[EW-1];
            end
        end
    end

    assign write      = write_reg;
    assign read       = read_reg;
    assign rsp_valid  = rsp_valid_reg;
    assign rsp_data   = rsp_data_reg;
    assign address    = address_reg;
    assign data_write = data_write_reg;

endmodule
